// File: rtl/pair_sched.sv
// Two-requester burst-limited arbiter feeding a shared one-cycle stage.
// x = a ^ c and y = b of the grantee, with c a per-requester invert mask.
module pair_sched #(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  input  logic hold,
  input  logic cfg_we,
  input  logic cfg_sel,
  input  logic cfg_c,
  output logic gnt0,
  output logic gnt1,
  output logic x,
  output logic y,
  output logic vld,
  output logic tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [2:0] CNT_MAX = 3'(BURST - 1);

  state_t     state_r, state_s;
  logic [2:0] cnt_r, cnt_s;
  logic       last_r, last_s;
  logic [1:0] c_r;
  logic       x_r, y_r, vld_r, tag_r;
  logic       gnt_s, gidx_s;
  logic       own_s, req_own_s, req_oth_s;

  // Next-state and grant decision; hold freezes everything and grants nothing.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    last_s    = last_r;
    gnt_s     = 1'b0;
    gidx_s    = 1'b0;
    own_s     = (state_r == OWN1);
    req_own_s = own_s ? req1 : req0;
    req_oth_s = own_s ? req0 : req1;
    if (hold) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = 3'd0;
          if (req0 && req1) begin
            gnt_s  = 1'b1;
            gidx_s = ~last_r;
          end else if (req0 || req1) begin
            gnt_s  = 1'b1;
            gidx_s = req1;
          end else begin
            gnt_s  = 1'b0;
          end
        end
        OWN0, OWN1: begin
          if (req_own_s) begin
            gnt_s = 1'b1;
            if (cnt_r < CNT_MAX) begin
              gidx_s = own_s;
              cnt_s  = cnt_r + 3'd1;
            end else if (req_oth_s) begin
              gidx_s = ~own_s;
              cnt_s  = 3'd0;
            end else begin
              gidx_s = own_s;
              cnt_s  = 3'd0;
            end
          end else if (req_oth_s) begin
            gnt_s  = 1'b1;
            gidx_s = ~own_s;
            cnt_s  = 3'd0;
          end else begin
            cnt_s  = 3'd0;
          end
        end
        default: begin
          cnt_s = 3'd0;
        end
      endcase
      if (gnt_s) begin
        state_s = gidx_s ? OWN1 : OWN0;
        last_s  = gidx_s;
      end else begin
        state_s = IDLE;
      end
    end
  end

  // Grants are masked while reset is asserted so nothing leaks out mid-reset.
  assign gnt0 = rst_n & gnt_s & ~gidx_s;
  assign gnt1 = rst_n & gnt_s & gidx_s;

  // Arbiter state, mask registers and stage pipeline; stage reads the pre-write mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      last_r  <= 1'b1;
      c_r     <= 2'b00;
      x_r     <= 1'b0;
      y_r     <= 1'b0;
      vld_r   <= 1'b0;
      tag_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      vld_r   <= gnt_s;
      if (cfg_we) begin
        c_r[cfg_sel] <= cfg_c;
      end
      if (gnt_s) begin
        x_r   <= gidx_s ? (a1 ^ c_r[1]) : (a0 ^ c_r[0]);
        y_r   <= gidx_s ? b1 : b0;
        tag_r <= gidx_s;
      end
    end
  end

  assign x   = x_r;
  assign y   = y_r;
  assign vld = vld_r;
  assign tag = tag_r;

endmodule

// File: tb/tb_pair_sched.sv
// Directed testbench for pair_sched: BURST=4 main instance plus a BURST=1
// instance sharing the same stimulus for the strict-alternation case.
module tb_pair_sched;

  logic clk = 1'b0;
  logic rst_n, req0, req1, a0, b0, a1, b1, hold, cfg_we, cfg_sel, cfg_c;
  logic gnt0, gnt1, x, y, vld, tag;
  logic q_gnt0, q_gnt1, q_x, q_y, q_vld, q_tag;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pair_sched #(.BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .hold(hold),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_c(cfg_c),
    .gnt0(gnt0), .gnt1(gnt1), .x(x), .y(y), .vld(vld), .tag(tag)
  );

  pair_sched #(.BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .hold(hold),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_c(cfg_c),
    .gnt0(q_gnt0), .gnt1(q_gnt1), .x(q_x), .y(q_y), .vld(q_vld), .tag(q_tag)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Apply requests/hold at the falling edge, then check grant exclusivity.
  task automatic drive(input logic r0, input logic r1, input logic h);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    hold = h;
    #1;
    check("excl4", {7'd0, gnt0 & gnt1}, 8'd0);
    check("excl1", {7'd0, q_gnt0 & q_gnt1}, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic e0, input logic e1);
    check({name, "_g0"}, {7'd0, gnt0}, {7'd0, e0});
    check({name, "_g1"}, {7'd0, gnt1}, {7'd0, e1});
  endtask

  task automatic chk_out(input string name, input logic ex, input logic ey,
                         input logic ev, input logic et);
    check({name, "_x"},   {7'd0, x},   {7'd0, ex});
    check({name, "_y"},   {7'd0, y},   {7'd0, ey});
    check({name, "_vld"}, {7'd0, vld}, {7'd0, ev});
    check({name, "_tag"}, {7'd0, tag}, {7'd0, et});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp31[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp33[9]  = '{0, 0, 2, 2, 2, 0, 0, 1, 1};
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; hold = 1'b0;
    a0 = 1'b0; b0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_c = 1'b0;
    #2;
    chk_gnt("rst", 1'b0, 1'b0);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: latency-1 result, then an idle cycle holds x/y/tag.
    a0 = 1'b1; b0 = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    chk_gnt("single", 1'b1, 1'b0);
    tick();
    chk_out("single", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk_gnt("idle", 1'b0, 1'b0);
    tick();
    chk_out("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Continuous contention with BURST=4.
    do_reset();
    a0 = 1'b1; b0 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk_gnt($sformatf("burst%0d", i), exp31[i] == 0, exp31[i] == 1);
      tick();
      chk_out($sformatf("burst%0d", i), exp31[i] == 0, exp31[i] == 1, 1'b1, exp31[i] == 1);
    end

    // Mask write, then same-cycle write and grant uses the old mask.
    do_reset();
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_c = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    cfg_we = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    chk_gnt("mask", 1'b0, 1'b1);
    tick();
    chk_out("mask", 1'b0, 1'b0, 1'b1, 1'b1);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_c = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    cfg_we = 1'b0;
    chk_out("mask_old", 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk_out("mask_new", 1'b1, 1'b0, 1'b1, 1'b1);

    // Hold mid-burst, with a mask write to c0 during the freeze.
    do_reset();
    a0 = 1'b1; b0 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_c = 1'b1;
      end
      drive(1'b1, 1'b1, exp33[i] == 2);
      chk_gnt($sformatf("hold%0d", i), exp33[i] == 0, exp33[i] == 1);
      tick();
      cfg_we = 1'b0;
      if (exp33[i] == 2)
        chk_out($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      else if (exp33[i] == 0)
        chk_out($sformatf("hold%0d", i), i < 2, 1'b0, 1'b1, 1'b0);
      else
        chk_out($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Reset pulse during OWN1 with cnt=2 (seven contended grants in).
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk_out("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_gnt("mid_rst", 1'b0, 1'b0);
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    chk_gnt("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    // BURST=1 instance alternates every cycle under contention.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      check($sformatf("alt%0d_g0", i), {7'd0, q_gnt0}, {7'd0, (i % 2) == 0});
      check($sformatf("alt%0d_g1", i), {7'd0, q_gnt1}, {7'd0, (i % 2) == 1});
      tick();
      check($sformatf("alt%0d_tag", i), {7'd0, q_tag}, {7'd0, (i % 2) == 1});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pair_sched.md
PAIR_SCHED -- requirements
Module: pair_sched

Interface
REQ-001 Parameter BURST, default 4, meaning max consecutive grants to one requester while the other is requesting; legal range 1..8.
REQ-002 clk  in  1  rising-edge clock, sole clock of the block.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req0, req1  in  1 each  per-requester request, level; sampled every cycle.
REQ-005 a0, b0, a1, b1  in  1 each  per-requester operands for the shared stage.
REQ-006 hold  in  1  freeze: no grants, stage and arbiter state frozen.
REQ-007 cfg_we, cfg_sel, cfg_c  in  1 each  write enable, target requester (0/1), invert-mask value.
REQ-008 gnt0, gnt1  out  1 each  combinational grant for the current cycle; at most one high.
REQ-009 x, y  out  1 each  registered stage outputs: x = a^c, y = b of the granted requester.
REQ-010 vld  out  1  registered; high for one cycle per accepted grant.
REQ-011 tag  out  1  registered; index of the requester whose result is on x/y.

Function
REQ-012 State machine states IDLE, OWN0, OWN1; plus cnt (3-bit consecutive-grant count minus one) and last (index of most recent grantee).
REQ-013 With hold=0 and no req, no grant; next state IDLE, cnt=0, last unchanged.
REQ-014 IDLE, exactly one req: that requester is granted; next state OWNk, cnt=0.
REQ-015 IDLE, both req: requester !last is granted; next state OWN(!last), cnt=0.
REQ-016 OWNk, req_k, cnt<BURST-1: k is granted; cnt increments; state unchanged.
REQ-017 OWNk, req_k, cnt==BURST-1, req of other high: other is granted; next state OWN(other), cnt=0.
REQ-018 OWNk, req_k, cnt==BURST-1, other idle: k is granted; cnt=0; state unchanged.
REQ-019 OWNk, !req_k, other req: other is granted; next state OWN(other), cnt=0.
REQ-020 last is updated to the grantee on every granted cycle.
REQ-021 BURST=1: under continuous contention, grants strictly alternate every cycle.
REQ-022 Grant in cycle N: operands a/b of the grantee and its mask c0/c1 are captured at the end of N; x, y, tag, vld=1 are valid in cycle N+1 (latency 1).
REQ-023 Cycle with no grant: vld=0 next cycle; x, y, tag hold their previous values.
REQ-024 hold=1: gnt0=gnt1=0; state, cnt, last, x, y, tag hold; vld=0 next cycle; cfg writes still take effect.
REQ-025 cfg_we=1 writes cfg_c into c[cfg_sel] at the clock edge; a grant to the same requester in the same cycle uses the old mask value.
REQ-026 Requests are not latched: dropping req before a grant loses nothing and produces no result.

Reset
REQ-027 rst_n low asynchronously forces state=IDLE, cnt=0, last=1, c0=c1=0, x=y=vld=tag=0.
REQ-028 gnt0=gnt1=0 while rst_n is low; a reset mid-burst discards the in-flight result (vld=0).
REQ-029 First cycle after rst_n release with both req high grants requester 0.

Verification
REQ-030 Reset, then req0=1, a0=1, b0=0, c0=0 for 1 cycle -> gnt0 in cycle 1; cycle 2: x=1, y=0, vld=1, tag=0.
REQ-031 BURST=4, req0=req1=1 held 10 cycles after reset -> grants 0,0,0,0,1,1,1,1,0,0; vld=1 every cycle from cycle 2.
REQ-032 cfg_we=1, cfg_sel=1, cfg_c=1, then req1=1, a1=1 -> x=0, tag=1; same-cycle write and grant -> x uses old mask.
REQ-033 Continuous contention, hold=1 for 3 cycles mid-burst -> no grants, vld=0, x/y/tag frozen; burst resumes with cnt preserved.
REQ-034 rst_n pulsed low during OWN1 with cnt=2 -> outputs 0 immediately; after release, both req -> gnt0.
REQ-035 BURST=1, req0=req1=1 for 6 cycles -> grants 0,1,0,1,0,1; gnt0 and gnt1 never high together in any test.
